// File: rtl/ext_bus_pkg.sv
// Shared types and constants for the external bus controller.
package ext_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        AH_SET,
        AH_HOLD,
        AL_SET,
        AL_HOLD,
        ACC,
        REC
    } bus_state_t;

    localparam int PORT_DATA  = 0;
    localparam int PORT_FETCH = 1;

    // Inactive levels of the pad strobes.
    localparam logic STROBE_IDLE = 1'b1;
    localparam logic LE_IDLE     = 1'b0;

endpackage

// File: rtl/ext_bus_ctrl_if.sv
// Requester handshakes and external pad signals of the bus controller.
interface ext_bus_ctrl_if;

    logic        p0_req,   p1_req;
    logic        p0_we,    p1_we;
    logic [31:0] p0_addr,  p1_addr;
    logic [15:0] p0_wdata, p1_wdata;
    logic [1:0]  p0_be,    p1_be;
    logic        p0_ack,   p1_ack;
    logic [15:0] rdata;

    logic [15:0] db_out;
    logic        db_oe;
    logic [15:0] db_in;
    logic        le_hi, le_lo;
    logic        bdir;
    logic        OEb;
    logic        WEb_lo, WEb_hi;

    modport master (
        input  p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr,
               p0_wdata, p1_wdata, p0_be, p1_be, db_in,
        output p0_ack, p1_ack, rdata, db_out, db_oe, le_hi, le_lo,
               bdir, OEb, WEb_lo, WEb_hi
    );

    modport slave (
        output p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr,
               p0_wdata, p1_wdata, p0_be, p1_be, db_in,
        input  p0_ack, p1_ack, rdata, db_out, db_oe, le_hi, le_lo,
               bdir, OEb, WEb_lo, WEb_hi
    );

endinterface

// File: rtl/ext_bus_arb.sv
// Two-way round-robin arbiter; the port not granted last wins a tie.
module ext_bus_arb (
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] req_i,
    input  logic       adv_i,
    output logic [1:0] gnt_o,
    output logic       last_grant_o
);

    logic last_grant_q, last_grant_d;

    always_comb begin
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_grant_q ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (adv_i && (|req_i)) last_grant_d = gnt_o[1];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) last_grant_q <= 1'b1;
        else       last_grant_q <= last_grant_d;
    end

    assign last_grant_o = last_grant_q;

endmodule

// File: rtl/ext_bus_ctrl.sv
// Multiplexed 16-bit external bus sequencer: address-latch phases, then a read
// or write strobe, shared between data (port 0) and fetch (port 1).
module ext_bus_ctrl
    import ext_bus_pkg::*;
#(
    parameter int WAIT_STATES = 2,
    parameter int HI_SKIP     = 1
) (
    input logic            clk,
    input logic            rstn,
    ext_bus_ctrl_if.master bus
);

    localparam int            WW        = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_STATES - 1);

    bus_state_t    state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [31:0]   addr_q, addr_d;
    logic          we_q, we_d;
    logic [15:0]   wdata_q, wdata_d;
    logic [1:0]    be_q, be_d;
    logic          hi_valid_q, hi_valid_d;
    logic [15:0]   hi_last_q, hi_last_d;
    logic          le_hi_q, le_hi_d, le_lo_q, le_lo_d;
    logic          oeb_q, oeb_d, web_lo_q, web_lo_d, web_hi_q, web_hi_d;
    logic          db_oe_q, db_oe_d, bdir_q, bdir_d;
    logic [15:0]   db_out_q, db_out_d, rdata_q, rdata_d;
    logic [1:0]    ack_q, ack_d;

    logic [1:0]    req, gnt;
    logic          adv, last_grant, sel;
    logic [31:0]   sel_addr;

    assign req      = {bus.p1_req, bus.p0_req};
    assign adv      = (state_q == IDLE);
    assign sel      = gnt[PORT_FETCH];
    assign sel_addr = sel ? bus.p1_addr : bus.p0_addr;

    ext_bus_arb u_arb (
        .clk          (clk),
        .rstn         (rstn),
        .req_i        (req),
        .adv_i        (adv),
        .gnt_o        (gnt),
        .last_grant_o (last_grant)
    );

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        wait_d     = wait_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        hi_valid_d = hi_valid_q;
        hi_last_d  = hi_last_q;
        rdata_d    = rdata_q;
        db_out_d   = db_out_q;
        le_hi_d    = LE_IDLE;
        le_lo_d    = LE_IDLE;
        oeb_d      = STROBE_IDLE;
        web_lo_d   = STROBE_IDLE;
        web_hi_d   = STROBE_IDLE;
        db_oe_d    = 1'b0;
        bdir_d     = 1'b0;
        ack_d      = 2'b00;

        case (state_q)
            IDLE: if (|req) begin
                addr_d  = sel_addr;
                we_d    = sel ? bus.p1_we    : bus.p0_we;
                wdata_d = sel ? bus.p1_wdata : bus.p0_wdata;
                be_d    = sel ? bus.p1_be    : bus.p0_be;
                if ((HI_SKIP != 0) && hi_valid_q && (sel_addr[31:16] == hi_last_q))
                    state_d = AL_SET;
                else
                    state_d = AH_SET;
            end
            AH_SET:  state_d = AH_HOLD;
            AH_HOLD: begin
                state_d    = AL_SET;
                hi_valid_d = 1'b1;
                hi_last_d  = addr_q[31:16];
            end
            AL_SET:  state_d = AL_HOLD;
            AL_HOLD: begin
                state_d = ACC;
                wait_d  = '0;
            end
            ACC: begin
                if (wait_q == WAIT_LAST) begin
                    state_d = REC;
                    if (!we_q) rdata_d = bus.db_in;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            REC:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Pads are registered from the state being entered, so they line up with it.
        case (state_d)
            AH_SET: begin
                {db_oe_d, bdir_d} = 2'b11;
                db_out_d          = addr_d[31:16];
                le_hi_d           = 1'b1;
            end
            AH_HOLD, AL_HOLD: {db_oe_d, bdir_d} = 2'b11;
            AL_SET: begin
                {db_oe_d, bdir_d} = 2'b11;
                db_out_d          = addr_d[15:0];
                le_lo_d           = 1'b1;
            end
            ACC: begin
                if (we_d) begin
                    {db_oe_d, bdir_d} = 2'b11;
                    db_out_d          = wdata_d;
                    web_lo_d          = ~be_d[0];
                    web_hi_d          = ~be_d[1];
                end else begin
                    oeb_d = 1'b0;
                end
            end
            REC: begin
                if (we_d) {db_oe_d, bdir_d} = 2'b11;
                ack_d[last_grant] = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            wait_q     <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            be_q       <= '0;
            hi_valid_q <= 1'b0;
            hi_last_q  <= '0;
            le_hi_q    <= LE_IDLE;
            le_lo_q    <= LE_IDLE;
            oeb_q      <= STROBE_IDLE;
            web_lo_q   <= STROBE_IDLE;
            web_hi_q   <= STROBE_IDLE;
            db_oe_q    <= 1'b0;
            bdir_q     <= 1'b0;
            db_out_q   <= '0;
            rdata_q    <= '0;
            ack_q      <= 2'b00;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q    <= state_d;
            wait_q     <= wait_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            hi_valid_q <= hi_valid_d;
            hi_last_q  <= hi_last_d;
            le_hi_q    <= le_hi_d;
            le_lo_q    <= le_lo_d;
            oeb_q      <= oeb_d;
            web_lo_q   <= web_lo_d;
            web_hi_q   <= web_hi_d;
            db_oe_q    <= db_oe_d;
            bdir_q     <= bdir_d;
            db_out_q   <= db_out_d;
            rdata_q    <= rdata_d;
            ack_q      <= ack_d;
        end
    end

    assign bus.le_hi  = le_hi_q;
    assign bus.le_lo  = le_lo_q;
    assign bus.OEb    = oeb_q;
    assign bus.WEb_lo = web_lo_q;
    assign bus.WEb_hi = web_hi_q;
    assign bus.db_oe  = db_oe_q;
    assign bus.bdir   = bdir_q;
    assign bus.db_out = db_out_q;
    assign bus.rdata  = rdata_q;
    assign bus.p0_ack = ack_q[PORT_DATA];
    assign bus.p1_ack = ack_q[PORT_FETCH];

endmodule

// File: tb/tb_ext_bus_ctrl.sv
// Bench for ext_bus_ctrl: external latch+RAM device, access-level model of the
// pad sequence checked every cycle, and directed scenarios with literal checks.
module tb_ext_bus_ctrl;

    localparam int WS = 2;
    localparam logic [31:0] IDLE_PADS = 32'h0000_0070;

    logic clk = 1'b0;
    logic rstn;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    ext_bus_ctrl_if bus ();
    ext_bus_ctrl_if bus1 ();

    ext_bus_ctrl #(.WAIT_STATES(WS), .HI_SKIP(1)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    ext_bus_ctrl #(.WAIT_STATES(1), .HI_SKIP(1)) dut1 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    endtask

    // ---------------- external device: address latches + RAM ----------------
    function automatic logic [9:0] hidx(input logic [31:0] a);
        return {a[17:16], a[7:0]};
    endfunction

    function automatic logic [15:0] ram_init(input logic [9:0] i);
        if (i == hidx(32'h0001_0004)) return 16'hBEEF;
        if (i == hidx(32'h0001_0006)) return 16'h5566;
        return 16'hA000 ^ {6'b0, i};
    endfunction

    logic [15:0] lat_hi, lat_lo;
    logic [15:0] dev_mem [1024];

    always @(negedge bus.le_hi) lat_hi = bus.db_out;
    always @(negedge bus.le_lo) lat_lo = bus.db_out;

    assign bus.db_in  = !bus.OEb ? dev_mem[hidx({lat_hi, lat_lo})] : 16'h0000;
    assign bus1.db_in = !bus1.OEb ? 16'h5A5A : 16'h0000;

    always @(posedge clk) begin
        if (!bus.WEb_lo) dev_mem[hidx({lat_hi, lat_lo})][7:0]  = bus.db_out[7:0];
        if (!bus.WEb_hi) dev_mem[hidx({lat_hi, lat_lo})][15:8] = bus.db_out[15:8];
    end

    // ---------------- access-level model ----------------
    typedef struct packed {
        logic        le_hi, le_lo, oeb, web_hi, web_lo, db_oe, bdir, ack1, ack0;
        logic [15:0] db;
        logic        rd_chk;
        logic [15:0] rd;
    } exp_t;

    exp_t        sched[$];
    int          grant_log[$];
    logic        m_last;
    logic        m_hi_valid;
    logic [15:0] m_hi_last;
    logic [15:0] mdl_mem [int];

    function automatic exp_t idle_e();
        exp_t e = '0;
        e.oeb = 1'b1; e.web_hi = 1'b1; e.web_lo = 1'b1;
        return e;
    endfunction

    function automatic logic [31:0] exp_vec(input exp_t e);
        return {23'b0, e.le_hi, e.le_lo, e.oeb, e.web_hi, e.web_lo, e.db_oe, e.bdir, e.ack1, e.ack0};
    endfunction

    function automatic logic [31:0] pad_vec();
        return {23'b0, bus.le_hi, bus.le_lo, bus.OEb, bus.WEb_hi, bus.WEb_lo,
                bus.db_oe, bus.bdir, bus.p1_ack, bus.p0_ack};
    endfunction

    function automatic logic [15:0] mdl_rd(input logic [9:0] i);
        return mdl_mem.exists(int'(i)) ? mdl_mem[int'(i)] : ram_init(i);
    endfunction

    // Expected pad values for each cycle of one access, starting the cycle after grant.
    task automatic plan(input int p, input logic we, input logic [31:0] addr,
                        input logic [15:0] wdata, input logic [1:0] be);
        exp_t e;
        logic [15:0] w;
        if (!(m_hi_valid && addr[31:16] == m_hi_last)) begin
            e = idle_e(); e.le_hi = 1; e.db_oe = 1; e.bdir = 1; e.db = addr[31:16];
            sched.push_back(e);
            e.le_hi = 0;
            sched.push_back(e);
            m_hi_valid = 1'b1;
            m_hi_last  = addr[31:16];
        end
        e = idle_e(); e.le_lo = 1; e.db_oe = 1; e.bdir = 1; e.db = addr[15:0];
        sched.push_back(e);
        e.le_lo = 0;
        sched.push_back(e);
        for (int i = 0; i < WS; i++) begin
            e = idle_e();
            if (we) begin
                e.db_oe = 1; e.bdir = 1; e.db = wdata; e.web_lo = ~be[0]; e.web_hi = ~be[1];
            end else begin
                e.oeb = 0;
            end
            sched.push_back(e);
        end
        e = idle_e();
        if (we) begin
            e.db_oe = 1; e.bdir = 1; e.db = wdata;
        end else begin
            e.rd_chk = 1; e.rd = mdl_rd(hidx(addr));
        end
        if (p == 1) e.ack1 = 1; else e.ack0 = 1;
        sched.push_back(e);
        if (we) begin
            w = mdl_rd(hidx(addr));
            if (be[0]) w[7:0]  = wdata[7:0];
            if (be[1]) w[15:8] = wdata[15:8];
            mdl_mem[int'(hidx(addr))] = w;
        end
    endtask

    always @(negedge clk) begin : compare
        exp_t e;
        bit   idle;
        int   w;
        if (!rstn) begin
            sched.delete();
            m_last     = 1'b1;
            m_hi_valid = 1'b0;
            m_hi_last  = '0;
            check("pads_in_reset", pad_vec(), exp_vec(idle_e()));
        end else begin
            idle = (sched.size() == 0);
            e    = idle ? idle_e() : sched.pop_front();
            check("pads", pad_vec(), exp_vec(e));
            if (e.db_oe) check("db_out", 32'(bus.db_out), 32'(e.db));
            if (e.rd_chk) check("rdata", 32'(bus.rdata), 32'(e.rd));
            if (idle && (bus.p0_req || bus.p1_req)) begin
                if (bus.p0_req && bus.p1_req) w = m_last ? 0 : 1;
                else                          w = bus.p1_req ? 1 : 0;
                m_last = w[0];
                grant_log.push_back(w);
                if (w == 1) plan(1, bus.p1_we, bus.p1_addr, bus.p1_wdata, bus.p1_be);
                else        plan(0, bus.p0_we, bus.p0_addr, bus.p0_wdata, bus.p0_be);
            end
        end
    end

    // ---------------- stimulus ----------------
    // Called at posedge+1 in a cycle; returns at posedge+1 after the ack cycle.
    task automatic req_port(input int p, input logic we, input logic [31:0] addr,
                            input logic [15:0] wdata, input logic [1:0] be, output int lat);
        int n   = 0;
        bit got = 0;
        if (p == 0) begin
            bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wdata; bus.p0_be = be; bus.p0_req = 1;
        end else begin
            bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wdata; bus.p1_be = be; bus.p1_req = 1;
        end
        while (!got && n < 60) begin
            @(negedge clk);
            n++;
            got = (p == 0) ? bus.p0_ack : bus.p1_ack;
        end
        check("ack_seen", 32'(got), 32'd1);
        lat = n - 1;
        @(posedge clk);
        #1;
        if (p == 0) bus.p0_req = 0; else bus.p1_req = 0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int lat, lat_a, lat_b, n, oe_low, gn;
        bit got;
        for (int i = 0; i < 1024; i++) dev_mem[i] = ram_init(10'(i));
        {bus.p0_req, bus.p1_req, bus.p0_we, bus.p1_we} = '0;
        {bus.p0_addr, bus.p1_addr, bus.p0_wdata, bus.p1_wdata, bus.p0_be, bus.p1_be} = '0;
        {bus1.p0_req, bus1.p1_req, bus1.p0_we, bus1.p1_we} = '0;
        {bus1.p0_addr, bus1.p1_addr, bus1.p0_wdata, bus1.p1_wdata, bus1.p0_be, bus1.p1_be} = '0;
        rstn = 1'b1;
        #1 rstn = 1'b0;
        #20;
        check("reset_pads", pad_vec(), IDLE_PADS);
        check("reset_rdata", 32'(bus.rdata), 32'h0);
        check("reset_db_out", 32'(bus.db_out), 32'h0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;

        // Cold read: full address phases.
        req_port(0, 0, 32'h0001_0004, 16'h0, 2'b00, lat);
        check("cold_read_latency", 32'(lat), 32'd7);
        check("cold_read_rdata", 32'(bus.rdata), 32'h0000_BEEF);
        check("cold_latch_hi", 32'(lat_hi), 32'h0001);
        check("cold_latch_lo", 32'(lat_lo), 32'h0004);

        // Byte write in the same upper page: hi phase skipped.
        req_port(0, 1, 32'h0001_0006, 16'h12AB, 2'b01, lat);
        check("byte_write_latency", 32'(lat), 32'd5);
        check("byte_write_ram", 32'(dev_mem[hidx(32'h0001_0006)]), 32'h0000_55AB);

        // Upper-address changes force the hi phase again.
        req_port(0, 0, 32'h0000_0010, 16'h0, 2'b00, lat);
        check("upper_change1_latency", 32'(lat), 32'd7);
        req_port(0, 0, 32'h0002_0010, 16'h0, 2'b00, lat);
        check("upper_change2_latency", 32'(lat), 32'd7);
        check("upper_latch_hi", 32'(lat_hi), 32'h0002);
        check("upper_latch_lo", 32'(lat_lo), 32'h0010);

        // Contention: both ports keep requesting.
        fork
            begin
                req_port(0, 0, 32'h0003_0020, 16'h0, 2'b00, lat_a);
                req_port(0, 1, 32'h0003_0022, 16'hC0DE, 2'b11, lat_a);
            end
            begin
                req_port(1, 0, 32'h0003_0040, 16'h0, 2'b00, lat_b);
                req_port(1, 0, 32'h0003_0042, 16'h0, 2'b00, lat_b);
            end
        join
        gn = grant_log.size();
        check("rr_order", {28'b0, grant_log[gn-4][0], grant_log[gn-3][0],
                           grant_log[gn-2][0], grant_log[gn-1][0]}, 32'b1010);
        check("contention_write_ram", 32'(dev_mem[hidx(32'h0003_0022)]), 32'h0000_C0DE);

        // Reset in the middle of a write strobe.
        bus.p0_we = 1; bus.p0_addr = 32'h0000_0050; bus.p0_wdata = 16'h7777; bus.p0_be = 2'b11;
        bus.p0_req = 1;
        got = 0; n = 0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            got = !bus.WEb_lo;
        end
        check("rst_mid_write_strobe_seen", 32'(got), 32'd1);
        #1 rstn = 1'b0;
        bus.p0_req = 0;
        #1;
        check("rst_mid_write_pads", pad_vec(), IDLE_PADS);
        check("rst_mid_write_db_out", 32'(bus.db_out), 32'h0);
        @(negedge clk);
        @(posedge clk);
        #1 rstn = 1'b1;
        req_port(1, 0, 32'h0000_0060, 16'h0, 2'b00, lat);
        check("post_reset_latency", 32'(lat), 32'd7);
        check("post_reset_rdata", 32'(bus.rdata), 32'h0000_A060);

        // WAIT_STATES=1 instance.
        @(posedge clk);
        #1;
        bus1.p0_we = 0; bus1.p0_addr = 32'h0000_0100; bus1.p0_req = 1;
        got = 0; n = 0; oe_low = 0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (!bus1.OEb) oe_low++;
            got = bus1.p0_ack;
        end
        check("ws1_ack_seen", 32'(got), 32'd1);
        check("ws1_latency", 32'(n - 1), 32'd6);
        check("ws1_oe_cycles", 32'(oe_low), 32'd1);
        check("ws1_rdata", 32'(bus1.rdata), 32'h0000_5A5A);
        check("ws1_p1_ack_quiet", 32'(bus1.p1_ack), 32'd0);
        @(posedge clk);
        #1 bus1.p0_req = 0;

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
